// File: rtl/apb_master_if.sv
// Command/response and APB bus bundle between the local requester and the APB slaves.
// master modport is the bridge's view; slave modport is the command source plus slave side.
interface apb_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SLV_NUM    = 2
);
    logic                          cmd_valid;
    logic                          cmd_ready;
    logic                          cmd_write;
    logic [ADDR_WIDTH-1:0]         cmd_addr;
    logic [DATA_WIDTH-1:0]         cmd_wdata;
    logic                          rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic                          rsp_err;
    logic [ADDR_WIDTH-1:0]         paddr;
    logic                          pwrite;
    logic [SLV_NUM-1:0]            psel;
    logic                          penable;
    logic [DATA_WIDTH-1:0]         pwdata;
    logic [SLV_NUM*DATA_WIDTH-1:0] prdata;
    logic [SLV_NUM-1:0]            pready;
    logic [SLV_NUM-1:0]            pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, paddr, pwrite, psel, penable, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, paddr, pwrite, psel, penable, pwdata
    );
endinterface

// File: rtl/apb_master.sv
// APB requester: one outstanding command -> SETUP/ACCESS transfer to a decoded slave.
// Latency: response pulse 3 cycles after accept plus one per wait state; decode error in 1.
// Backpressure: cmd_ready only in IDLE; response is a one-cycle pulse with no backpressure.
module apb_master #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int SLV_NUM     = 2,
    parameter int SLV_SEL_LSB = 7,
    parameter int TIMEOUT     = 15
) (
    input  logic         i_pclk,
    input  logic         i_prst,
    apb_master_if.master bus
);
    localparam int SEL_W = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                 state;
    logic [SEL_W-1:0]       sel_idx;
    logic [CNT_W-1:0]       wait_cnt;
    logic [SEL_W-1:0]       cmd_idx;
    logic                   cmd_idx_ok;
    logic                   sel_rdy;
    logic                   sel_err;
    logic [DATA_WIDTH-1:0]  sel_rdata;

    assign cmd_idx       = bus.cmd_addr[SLV_SEL_LSB +: SEL_W];
    assign cmd_idx_ok    = {1'b0, cmd_idx} < (SEL_W + 1)'(SLV_NUM);
    assign bus.cmd_ready = (state == IDLE);

    // Only the slave latched at accept time is looked at; the rest are don't-care.
    always_comb begin
        sel_rdy   = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < SLV_NUM; k++) begin
            if (sel_idx == SEL_W'(k)) begin
                sel_rdy   = bus.pready[k];
                sel_err   = bus.pslverr[k];
                sel_rdata = bus.prdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge i_pclk) begin
        if (i_prst) begin
            state         <= IDLE;
            sel_idx       <= '0;
            wait_cnt      <= '0;
            bus.paddr     <= '0;
            bus.pwrite    <= 1'b0;
            bus.pwdata    <= '0;
            bus.psel      <= '0;
            bus.penable   <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.paddr  <= bus.cmd_addr;
                        bus.pwrite <= bus.cmd_write;
                        bus.pwdata <= bus.cmd_wdata;
                        sel_idx    <= cmd_idx;
                        if (cmd_idx_ok) begin
                            bus.psel    <= SLV_NUM'(1) << cmd_idx;
                            bus.penable <= 1'b0;
                            state       <= SETUP;
                        end else begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= '0;
                        end
                    end
                end
                SETUP: begin
                    bus.penable <= 1'b1;
                    wait_cnt    <= '0;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    if (sel_rdy) begin
                        bus.psel      <= '0;
                        bus.penable   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= sel_err;
                        bus.rsp_rdata <= bus.pwrite ? '0 : sel_rdata;
                        state         <= IDLE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        bus.psel      <= '0;
                        bus.penable   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rdata <= '0;
                        state         <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with three slaves: zero-wait, wait states, slave error,
// decode error, timeout abort and reset during ACCESS.
module tb_apb_master;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NS = 3;
    localparam int TO = 15;

    logic pclk = 1'b0;
    logic prst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   lat;

    always #5 pclk = ~pclk;

    apb_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLV_NUM(NS)) bus ();

    apb_master #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .SLV_NUM    (NS),
        .SLV_SEL_LSB(7),
        .TIMEOUT    (TO)
    ) dut (
        .i_pclk(pclk),
        .i_prst(prst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // lat counts cycles from the accept edge in the same way as the response latency (3 = no waits)
    task automatic wait_rsp(input int max, output int cyc);
        cyc = 1;
        while (!bus.rsp_valid && cyc < max) begin
            tick();
            cyc++;
        end
        chk("rsp_seen", 64'(bus.rsp_valid), 64'd1);
    endtask

    task automatic set_rdata(input int k, input logic [DW-1:0] v);
        bus.prdata[k*DW +: DW] = v;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.prdata    = '0;
        bus.pready    = '0;
        bus.pslverr   = '0;
        prst = 1'b1;
        tick();
        tick();
        chk("rst_psel",      64'(bus.psel),      64'd0);
        chk("rst_penable",   64'(bus.penable),   64'd0);
        chk("rst_paddr",     64'(bus.paddr),     64'd0);
        chk("rst_pwrite",    64'(bus.pwrite),    64'd0);
        chk("rst_pwdata",    64'(bus.pwdata),    64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        chk("rst_rsp_err",   64'(bus.rsp_err),   64'd0);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        prst = 1'b0;
        tick();

        // zero-wait write to slave 0
        bus.pready = 3'b001;
        issue(1'b1, 32'h08, 32'hDEADBEEF);
        chk("w0_setup_psel",    64'(bus.psel),      64'd1);
        chk("w0_setup_penable", 64'(bus.penable),   64'd0);
        chk("w0_paddr",         64'(bus.paddr),     64'h08);
        chk("w0_pwrite",        64'(bus.pwrite),    64'd1);
        chk("w0_pwdata",        64'(bus.pwdata),    64'hDEADBEEF);
        chk("w0_cmd_ready",     64'(bus.cmd_ready), 64'd0);
        tick();
        chk("w0_access_psel",    64'(bus.psel),    64'd1);
        chk("w0_access_penable", 64'(bus.penable), 64'd1);
        chk("w0_no_rsp_yet",     64'(bus.rsp_valid), 64'd0);
        tick();
        chk("w0_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("w0_rsp_err",   64'(bus.rsp_err),   64'd0);
        chk("w0_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        chk("w0_psel_off",  64'(bus.psel),      64'd0);
        chk("w0_pen_off",   64'(bus.penable),   64'd0);
        chk("w0_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        tick();

        // zero-wait read from slave 0, other slaves present distinct data
        set_rdata(0, 32'hDEADBEEF);
        set_rdata(1, 32'hAAAA5555);
        set_rdata(2, 32'h0BADF00D);
        issue(1'b0, 32'h08, 32'h0);
        wait_rsp(10, lat);
        chk("r0_latency",   64'(lat),           64'd3);
        chk("r0_rsp_rdata", 64'(bus.rsp_rdata), 64'hDEADBEEF);
        chk("r0_rsp_err",   64'(bus.rsp_err),   64'd0);
        tick();
        chk("r0_pulse_one", 64'(bus.rsp_valid), 64'd0);
        chk("r0_rdata_hold", 64'(bus.rsp_rdata), 64'hDEADBEEF);

        // write answered with pslverr on the ready cycle
        bus.pready  = 3'b010;
        bus.pslverr = 3'b010;
        issue(1'b1, 32'h84, 32'h5A5A5A5A);
        chk("se_psel", 64'(bus.psel), 64'b010);
        wait_rsp(10, lat);
        chk("se_latency",   64'(lat),           64'd3);
        chk("se_rsp_err",   64'(bus.rsp_err),   64'd1);
        chk("se_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        tick();
        chk("se_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("se_psel_off",  64'(bus.psel),      64'd0);

        // slave 1 read with 3 wait states; slave 1 flags error only while not ready
        bus.pready  = 3'b101;
        bus.pslverr = 3'b111;
        set_rdata(1, 32'h12345678);
        issue(1'b0, 32'h80, 32'h0);
        chk("ws_psel",   64'(bus.psel),   64'b010);
        chk("ws_pwrite", 64'(bus.pwrite), 64'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 32'h100;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("ws_paddr_%0d", i),   64'(bus.paddr),     64'h80);
            chk($sformatf("ws_psel_%0d", i),    64'(bus.psel),      64'b010);
            chk($sformatf("ws_penable_%0d", i), 64'(bus.penable),   64'd1);
            chk($sformatf("ws_no_rsp_%0d", i),  64'(bus.rsp_valid), 64'd0);
        end
        bus.cmd_valid = 1'b0;
        bus.pready    = 3'b111;
        bus.pslverr   = 3'b101;
        tick();
        chk("ws_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("ws_rsp_rdata", 64'(bus.rsp_rdata), 64'h12345678);
        chk("ws_rsp_err",   64'(bus.rsp_err),   64'd0);
        tick();

        // decode error: index 3 with three slaves
        bus.pslverr = 3'b000;
        issue(1'b0, 32'h180, 32'h0);
        chk("de_psel",      64'(bus.psel),      64'd0);
        chk("de_penable",   64'(bus.penable),   64'd0);
        chk("de_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("de_rsp_err",   64'(bus.rsp_err),   64'd1);
        chk("de_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        chk("de_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        tick();
        chk("de_pulse_one", 64'(bus.rsp_valid), 64'd0);

        // timeout abort with pready stuck low, then a normal transfer
        bus.pready = 3'b000;
        issue(1'b0, 32'h08, 32'h0);
        wait_rsp(40, lat);
        chk("to_latency",   64'(lat),           64'd17);
        chk("to_rsp_err",   64'(bus.rsp_err),   64'd1);
        chk("to_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        chk("to_psel",      64'(bus.psel),      64'd0);
        chk("to_penable",   64'(bus.penable),   64'd0);
        chk("to_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        tick();
        bus.pready = 3'b001;
        issue(1'b1, 32'h0C, 32'h11112222);
        wait_rsp(10, lat);
        chk("after_to_latency", 64'(lat),         64'd3);
        chk("after_to_err",     64'(bus.rsp_err), 64'd0);
        tick();

        // reset asserted while in ACCESS
        bus.pready = 3'b000;
        issue(1'b0, 32'h88, 32'h0);
        tick();
        chk("rm_in_access", 64'(bus.penable), 64'd1);
        prst = 1'b1;
        tick();
        chk("rm_psel",      64'(bus.psel),      64'd0);
        chk("rm_penable",   64'(bus.penable),   64'd0);
        chk("rm_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        prst       = 1'b0;
        bus.pready = 3'b111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rm_no_rsp_%0d", i),   64'(bus.rsp_valid), 64'd0);
            chk($sformatf("rm_cmd_ready_%0d", i), 64'(bus.cmd_ready), 64'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
